// File: rtl/alu_seq_ctrl_pkg.sv
// Shared constants for the ALU sequencing controller: AluOp/funct codes,
// ALU operation encodings, latency selector and FSM state type.
package alu_ctrl_pkg;

   localparam int OP_W_DEF = 4;
   localparam int CNT_W    = 6;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;
   localparam logic [2:0] ALUOP_OR    = 3'b011;
   localparam logic [2:0] ALUOP_SLT   = 3'b100;
   localparam logic [2:0] ALUOP_AND   = 3'b101;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_MUL  = 6'b000010;
   localparam logic [5:0] F_DIVU = 6'b011011;
   localparam logic [5:0] F_SQRT = 6'b010110;

   localparam logic [OP_W_DEF-1:0] OP_AND  = 4'b0000;
   localparam logic [OP_W_DEF-1:0] OP_OR   = 4'b0001;
   localparam logic [OP_W_DEF-1:0] OP_ADD  = 4'b0010;
   localparam logic [OP_W_DEF-1:0] OP_MUL  = 4'b0011;
   localparam logic [OP_W_DEF-1:0] OP_DIV  = 4'b0100;
   localparam logic [OP_W_DEF-1:0] OP_SQRT = 4'b0101;
   localparam logic [OP_W_DEF-1:0] OP_SUB  = 4'b0110;
   localparam logic [OP_W_DEF-1:0] OP_SLT  = 4'b0111;
   localparam logic [OP_W_DEF-1:0] OP_SLL  = 4'b1111;

   typedef enum logic [1:0] {
      LAT_NONE,
      LAT_MUL,
      LAT_DIV,
      LAT_SQRT
   } lat_sel_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Instruction/result handshake between main control and the ALU sequencer.
interface alu_seq_ctrl_if #(
   parameter int OP_W = 4
);
   logic            valid_i;
   logic [2:0]      alu_op_i;
   logic [5:0]      funct_i;
   logic            flush_i;
   logic [OP_W-1:0] op_o;
   logic            op_valid_o;
   logic            stall_o;
   logic            done_o;
   logic            illegal_o;

   modport master (
      output valid_i, alu_op_i, funct_i, flush_i,
      input  op_o, op_valid_o, stall_o, done_o, illegal_o
   );

   modport slave (
      input  valid_i, alu_op_i, funct_i, flush_i,
      output op_o, op_valid_o, stall_o, done_o, illegal_o
   );
endinterface

// File: rtl/alu_op_decode.sv
// Pure combinational AluOp/funct decode: ALU op code, legality, and which
// latency (if any) the op needs.
module alu_op_decode
   import alu_ctrl_pkg::*;
#(
   parameter int OP_W = 4
) (
   input  logic [2:0]      alu_op,
   input  logic [5:0]      funct,
   output logic [OP_W-1:0] op,
   output logic            legal,
   output logic            multi,
   output lat_sel_t        lat_sel
);

   logic [OP_W_DEF-1:0] op_raw;

   always_comb begin
      op_raw  = OP_ADD;
      legal   = 1'b1;
      lat_sel = LAT_NONE;
      case (alu_op)
         ALUOP_ADD: op_raw = OP_ADD;
         ALUOP_SUB: op_raw = OP_SUB;
         ALUOP_OR:  op_raw = OP_OR;
         ALUOP_AND: op_raw = OP_AND;
         ALUOP_SLT: op_raw = OP_SLT;
         ALUOP_RTYPE: begin
            case (funct)
               F_ADD:  op_raw = OP_ADD;
               F_SUB:  op_raw = OP_SUB;
               F_AND:  op_raw = OP_AND;
               F_OR:   op_raw = OP_OR;
               F_SLT:  op_raw = OP_SLT;
               F_SLL:  op_raw = OP_SLL;
               F_MUL: begin
                  op_raw  = OP_MUL;
                  lat_sel = LAT_MUL;
               end
               F_DIVU: begin
                  op_raw  = OP_DIV;
                  lat_sel = LAT_DIV;
               end
               F_SQRT: begin
                  op_raw  = OP_SQRT;
                  lat_sel = LAT_SQRT;
               end
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
      // Illegal encodings report ADD so downstream sees a harmless op.
      if (!legal) begin
         op_raw  = OP_ADD;
         lat_sel = LAT_NONE;
      end
      multi = (lat_sel != LAT_NONE);
      op    = OP_W'(op_raw);
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencing controller: registers the decoded op and holds the pipeline
// for multi-cycle operations until their latency has elapsed.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no multi-cycle op in flight; accepts new instructions
// ST_RUN  | multi-cycle op executing; stall asserted, counter running
// ST_DONE | result ready this cycle (done pulse); may accept next op
module alu_seq_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int OP_W     = 4,
   parameter int MUL_LAT  = 4,
   parameter int DIV_LAT  = 32,
   parameter int SQRT_LAT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_ctrl_if.slave bus
);

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic             vld_q, vld_d;
   logic             ill_q, ill_d;

   logic [OP_W-1:0]  dec_op;
   logic             dec_legal;
   logic             dec_multi;
   lat_sel_t         dec_lat;
   logic [CNT_W-1:0] lat_load;
   logic             accept;

   alu_op_decode #(.OP_W(OP_W)) u_dec (
      .alu_op  (bus.alu_op_i),
      .funct   (bus.funct_i),
      .op      (dec_op),
      .legal   (dec_legal),
      .multi   (dec_multi),
      .lat_sel (dec_lat)
   );

   always_comb begin
      lat_load = '0;
      case (dec_lat)
         LAT_MUL:  lat_load = CNT_W'(MUL_LAT - 1);
         LAT_DIV:  lat_load = CNT_W'(DIV_LAT - 1);
         LAT_SQRT: lat_load = CNT_W'(SQRT_LAT - 1);
         default:  lat_load = '0;
      endcase
   end

   assign accept = bus.valid_i && (state != ST_RUN) && !bus.flush_i;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      op_d    = op_q;
      vld_d   = 1'b0;
      ill_d   = 1'b0;
      if (bus.flush_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (accept) begin
         op_d  = dec_op;
         vld_d = dec_legal;
         ill_d = !dec_legal;
         if (dec_legal && dec_multi) begin
            state_d = ST_RUN;
            cnt_d   = lat_load;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         case (state)
            ST_RUN: begin
               vld_d = 1'b1;
               if (cnt == '0) state_d = ST_DONE;
               else           cnt_d   = cnt - 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         op_q  <= '0;
         vld_q <= 1'b0;
         ill_q <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         op_q  <= op_d;
         vld_q <= vld_d;
         ill_q <= ill_d;
      end
   end

   // Stall and done come straight from the state register, never from inputs.
   assign bus.stall_o    = (state == ST_RUN);
   assign bus.done_o     = (state == ST_DONE);
   assign bus.op_o       = op_q;
   assign bus.op_valid_o = vld_q;
   assign bus.illegal_o  = ill_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: decode vector table, hand-written multi-cycle/flush/reset
// sequences and random traffic against a timeline-based reference model.
module tb_alu_seq_ctrl;

   localparam int MUL_LAT  = 1;
   localparam int DIV_LAT  = 32;
   localparam int SQRT_LAT = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_seq_ctrl_if #(.OP_W(4)) bus ();

   alu_seq_ctrl #(
      .OP_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a timeline of cycle numbers rather than a state machine.
   int         t;
   int         busy_end;
   int         done_cyc;
   logic [3:0] m_op;
   logic       m_fresh;
   logic       m_ill;
   logic [3:0] op_map [bit [8:0]];

   typedef struct {
      logic [2:0] a;
      logic [5:0] f;
      logic [3:0] op;
      logic       v;
      logic       ill;
   } vec_t;
   vec_t vecs [16];

   logic [5:0] functs [11];

   function automatic void init_map();
      op_map[{3'b000, 6'd0}]     = 4'b0010;
      op_map[{3'b001, 6'd0}]     = 4'b0110;
      op_map[{3'b011, 6'd0}]     = 4'b0001;
      op_map[{3'b101, 6'd0}]     = 4'b0000;
      op_map[{3'b100, 6'd0}]     = 4'b0111;
      op_map[{3'b010, 6'h20}]    = 4'b0010;
      op_map[{3'b010, 6'h22}]    = 4'b0110;
      op_map[{3'b010, 6'h24}]    = 4'b0000;
      op_map[{3'b010, 6'h25}]    = 4'b0001;
      op_map[{3'b010, 6'h2A}]    = 4'b0111;
      op_map[{3'b010, 6'h00}]    = 4'b1111;
      op_map[{3'b010, 6'h02}]    = 4'b0011;
      op_map[{3'b010, 6'h1B}]    = 4'b0100;
      op_map[{3'b010, 6'h16}]    = 4'b0101;
   endfunction

   function automatic bit ref_decode(input logic [2:0] a, input logic [5:0] f,
                                     output logic [3:0] op);
      bit [8:0] key;
      key = (a == 3'b010) ? {a, f} : {a, 6'd0};
      if (op_map.exists(key)) begin
         op = op_map[key];
         return 1'b1;
      end
      op = 4'b0010;
      return 1'b0;
   endfunction

   function automatic int ref_lat(input logic [3:0] op);
      if (op == 4'b0011) return MUL_LAT;
      if (op == 4'b0100) return DIV_LAT;
      if (op == 4'b0101) return SQRT_LAT;
      return 0;
   endfunction

   function automatic logic [7:0] dut_out();
      return {bus.op_o, bus.op_valid_o, bus.stall_o, bus.done_o, bus.illegal_o};
   endfunction

   function automatic logic [7:0] model_out();
      logic s, d;
      s = (t <= busy_end);
      d = (t == done_cyc);
      return {m_op, m_fresh | s | d, s, d, m_ill};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual{op,vld,stall,done,ill}=%b_%b required=%b_%b",
                  name, t, act[7:4], act[3:0], exp[7:4], exp[3:0]);
      end
   endtask

   task automatic model_reset();
      t        = 0;
      busy_end = -1;
      done_cyc = -1;
      m_op     = 4'b0000;
      m_fresh  = 1'b0;
      m_ill    = 1'b0;
   endtask

   // Called at a falling edge; applies inputs for cycle t, observes cycle t+1.
   task automatic step(input logic v, input logic [2:0] a, input logic [5:0] f,
                       input logic fl, output logic [7:0] act);
      logic [3:0] op;
      bit         legal;
      int         lat;
      bus.valid_i  = v;
      bus.alu_op_i = a;
      bus.funct_i  = f;
      bus.flush_i  = fl;
      m_fresh = 1'b0;
      m_ill   = 1'b0;
      if (fl) begin
         busy_end = t;
         done_cyc = -1;
      end else if (v && !(t <= busy_end)) begin
         legal   = ref_decode(a, f, op);
         m_op    = op;
         m_fresh = legal;
         m_ill   = !legal;
         lat     = ref_lat(op);
         if (legal && lat > 0) begin
            busy_end = t + lat;
            done_cyc = t + lat + 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      t++;
      act = dut_out();
      chk("model", act, model_out());
   endtask

   task automatic idle(output logic [7:0] act);
      step(1'b0, 3'b000, 6'd0, 1'b0, act);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("reset_async", dut_out(), 8'h00);
      model_reset();
      @(negedge clk);
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] act;
      int         ndone;

      vecs[0]  = '{3'b000, 6'h00, 4'b0010, 1'b1, 1'b0};
      vecs[1]  = '{3'b001, 6'h00, 4'b0110, 1'b1, 1'b0};
      vecs[2]  = '{3'b011, 6'h00, 4'b0001, 1'b1, 1'b0};
      vecs[3]  = '{3'b101, 6'h00, 4'b0000, 1'b1, 1'b0};
      vecs[4]  = '{3'b100, 6'h00, 4'b0111, 1'b1, 1'b0};
      vecs[5]  = '{3'b010, 6'h20, 4'b0010, 1'b1, 1'b0};
      vecs[6]  = '{3'b010, 6'h22, 4'b0110, 1'b1, 1'b0};
      vecs[7]  = '{3'b010, 6'h24, 4'b0000, 1'b1, 1'b0};
      vecs[8]  = '{3'b010, 6'h25, 4'b0001, 1'b1, 1'b0};
      vecs[9]  = '{3'b010, 6'h2A, 4'b0111, 1'b1, 1'b0};
      vecs[10] = '{3'b010, 6'h00, 4'b1111, 1'b1, 1'b0};
      vecs[11] = '{3'b111, 6'h00, 4'b0010, 1'b0, 1'b1};
      vecs[12] = '{3'b010, 6'h3F, 4'b0010, 1'b0, 1'b1};
      vecs[13] = '{3'b110, 6'h22, 4'b0010, 1'b0, 1'b1};
      vecs[14] = '{3'b000, 6'h2A, 4'b0010, 1'b1, 1'b0};
      vecs[15] = '{3'b010, 6'h01, 4'b0010, 1'b0, 1'b1};

      functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00,
                 6'h02, 6'h1B, 6'h16, 6'h3F, 6'h01};

      init_map();
      model_reset();
      rst_n        = 1'b1;
      bus.valid_i  = 1'b0;
      bus.alu_op_i = 3'b000;
      bus.funct_i  = 6'd0;
      bus.flush_i  = 1'b0;
      @(negedge clk);
      do_reset();
      idle(act);
      chk("post_reset_idle", act, 8'h00);

      // Single-cycle decode table, issued back to back.
      foreach (vecs[i]) begin
         step(1'b1, vecs[i].a, vecs[i].f, 1'b0, act);
         chk($sformatf("vec%0d", i), act, {vecs[i].op, vecs[i].v, 2'b00, vecs[i].ill});
      end
      idle(act);
      chk("no_fresh_accept", act, {4'b0010, 4'b0000});

      // DIVU: stall 32 cycles with valid_i ignored, done on 33rd.
      step(1'b1, 3'b010, 6'h1B, 1'b0, act);
      chk("div_c1", act, {4'b0100, 4'b1100});
      for (int k = 2; k <= 32; k++) begin
         step(1'b1, 3'b000, 6'd0, 1'b0, act);
         chk("div_run", act, {4'b0100, 4'b1100});
      end
      step(1'b1, 3'b000, 6'd0, 1'b0, act);
      chk("div_done", act, {4'b0100, 4'b1010});
      idle(act);
      chk("div_after", act, {4'b0100, 4'b0000});

      // MUL with LAT=1 then ADD accepted in DONE, then back-to-back mul->sqrt.
      step(1'b1, 3'b010, 6'h02, 1'b0, act);
      chk("mul_run1", act, {4'b0011, 4'b1100});
      idle(act);
      chk("mul_done", act, {4'b0011, 4'b1010});
      step(1'b1, 3'b000, 6'd0, 1'b0, act);
      chk("add_in_done", act, {4'b0010, 4'b1000});
      step(1'b1, 3'b010, 6'h02, 1'b0, act);
      idle(act);
      chk("mul_done2", act, {4'b0011, 4'b1010});

      // SQRT accepted in DONE, flushed at its 5th cycle.
      step(1'b1, 3'b010, 6'h16, 1'b0, act);
      chk("sqrt_b2b", act, {4'b0101, 4'b1100});
      for (int k = 0; k < 4; k++) idle(act);
      step(1'b0, 3'b000, 6'd0, 1'b1, act);
      chk("sqrt_flush", act, {4'b0101, 4'b0000});
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         idle(act);
         if (act[1]) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL no_done_after_flush actual=%0d required=0", ndone);
      end

      // Flush beats a simultaneous accept, and beats RUN completion.
      step(1'b1, 3'b001, 6'd0, 1'b1, act);
      chk("flush_vs_accept", act, {4'b0101, 4'b0000});
      step(1'b1, 3'b010, 6'h02, 1'b0, act);
      step(1'b0, 3'b000, 6'd0, 1'b1, act);
      chk("flush_vs_complete", act, {4'b0011, 4'b0000});
      idle(act);
      chk("flush_no_done", act, {4'b0011, 4'b0000});

      // Reset mid-RUN, then ADDI on the first edge after release.
      step(1'b1, 3'b010, 6'h1B, 1'b0, act);
      idle(act);
      do_reset();
      step(1'b1, 3'b000, 6'd0, 1'b0, act);
      chk("addi_after_reset", act, {4'b0010, 4'b1000});
      idle(act);
      chk("no_done_after_reset", act, {4'b0010, 4'b0000});

      // Random traffic checked against the timeline model.
      for (int k = 0; k < 600; k++) begin
         logic       v, fl;
         logic [2:0] a;
         logic [5:0] f;
         v  = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 24) == 0);
         a  = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
         f  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                          : functs[$urandom_range(0, 10)];
         step(v, a, f, fl, act);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
